vend_dispense_ctrl: RTL and testbench
=====================================

VEND_DISPENSE_CTRL -- requirements
Module: vend_dispense_ctrl

Interface
REQ-001 SHALL provide parameter MOTOR_CYC, default 16, number of cycles motor_on is asserted per vend.
REQ-002 SHALL provide parameter PULSE_CYC, default 4, width in cycles of one change-hopper pulse.
REQ-003 SHALL provide parameter GAP_CYC, default 4, low cycles following each change pulse.
REQ-004 SHALL provide parameter TMO_CYC, default 64, item-sensor timeout in cycles (used only with VEND_TIMEOUT_EN).
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 purchase  input  1  one-cycle vend request from the FSM stage upstream.
REQ-008 cash_return  input  2  change request: 00 none, 01 one 5-unit coin, 10 one 10-unit coin, 11 reserved.
REQ-009 item_sensor  input  1  high when an item has fallen past the chute sensor.
REQ-010 fault_clr  input  1  one-cycle fault acknowledge.
REQ-011 motor_on  output  1  vend motor drive.
REQ-012 coin5_out  output  1  5-unit hopper pulse.
REQ-013 coin10_out  output  1  10-unit hopper pulse.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 done  output  1  one-cycle pulse on transaction completion.
REQ-016 overrun  output  1  sticky; set when an event is dropped.
REQ-017 fault  output  1  high while in FAULT state.

Function
REQ-018 An event SHALL be any cycle with purchase=1 or cash_return in {01,10}; cash_return=11 SHALL be treated as 00.
REQ-019 States SHALL be IDLE, VEND, CHG_PULSE, CHG_GAP, DONE, and FAULT (FAULT only with VEND_TIMEOUT_EN).
REQ-020 An event sampled in IDLE at edge N SHALL enter VEND (purchase=1) or CHG_PULSE (purchase=0) at edge N, with outputs active from cycle N+1.
REQ-021 VEND SHALL hold motor_on=1 for exactly MOTOR_CYC cycles, then go to CHG_PULSE if latched change is nonzero, else DONE.
REQ-022 CHG_PULSE SHALL assert coin5_out (01) or coin10_out (10) for PULSE_CYC cycles, then CHG_GAP for GAP_CYC cycles with both low, then DONE.
REQ-023 DONE SHALL assert done=1 for one cycle and return to IDLE.
REQ-024 An event arriving while busy=1 SHALL be stored in a one-entry pending register if empty; IDLE SHALL start a pending event on the cycle after DONE, taking priority over a new input event, which is then stored as pending.
REQ-025 An event arriving while busy=1 with pending full SHALL be dropped and set overrun; overrun SHALL clear only on rst.
REQ-026 purchase and change in the same event SHALL execute vend first, then change, under a single done pulse.
REQ-027 motor_on, coin5_out and coin10_out SHALL never be high simultaneously.
REQ-028 Cycle counters SHALL be wide enough for the largest parameter and SHALL not wrap.

Reset
REQ-029 rst=1 SHALL force IDLE, clear pending, counters, overrun, and drive all outputs to 0 on the next edge, aborting any vend or pulse mid-operation.
REQ-030 Events sampled in a cycle with rst=1 SHALL be ignored.

Configuration
REQ-031 With VEND_TIMEOUT_EN defined, after the MOTOR_CYC motor period, VEND SHALL keep motor_on=1 until item_sensor=1 (then proceed per REQ-021) or TMO_CYC further cycles elapse, then enter FAULT.
REQ-032 FAULT SHALL drive fault=1, motor_on=0, skip change, discard pending, and return to IDLE on fault_clr=1 without a done pulse.
REQ-033 Without VEND_TIMEOUT_EN, item_sensor and fault_clr SHALL be ignored, fault SHALL be constant 0, and FAULT SHALL not exist.

Verification
REQ-034 purchase=1, cash_return=00 at cycle 10 -> motor_on cycles 11-26, done at 27, busy low at 28.
REQ-035 purchase=1, cash_return=10 -> 16 motor cycles, 4-cycle coin10_out, 4-cycle gap, single done.
REQ-036 purchase=0, cash_return=01 -> coin5_out cycles N+1..N+4, done at N+9; cash_return=11 -> no response.
REQ-037 Three events during one vend -> second runs after done, third dropped, overrun=1 until rst.
REQ-038 rst pulsed mid-vend -> motor_on=0 next cycle, pending cleared, no done.
REQ-039 VEND_TIMEOUT_EN, item_sensor held 0 -> fault=1 after 16+64 motor cycles; fault_clr -> IDLE, no change pulse.

Source files
------------

// File: rtl/vend_dispense_ctrl_if.sv
// Vend dispense controller bus: upstream requests and sensor inputs, motor/hopper drive outputs.
interface vend_dispense_ctrl_if;
  logic       purchase;
  logic [1:0] cash_return;
  logic       item_sensor;
  logic       fault_clr;
  logic       motor_on;
  logic       coin5_out;
  logic       coin10_out;
  logic       busy;
  logic       done;
  logic       overrun;
  logic       fault;

  modport slave (
    input  purchase, cash_return, item_sensor, fault_clr,
    output motor_on, coin5_out, coin10_out, busy, done, overrun, fault
  );

  modport master (
    output purchase, cash_return, item_sensor, fault_clr,
    input  motor_on, coin5_out, coin10_out, busy, done, overrun, fault
  );
endinterface

// File: rtl/vend_dispense_ctrl.sv
// Vend motor and change-hopper sequencer with a one-entry pending event slot.
// Optional item-sensor timeout and FAULT state enabled by defining VEND_TIMEOUT_EN.
module vend_dispense_ctrl #(
  parameter int unsigned MOTOR_CYC = 16,
  parameter int unsigned PULSE_CYC = 4,
  parameter int unsigned GAP_CYC   = 4,
  parameter int unsigned TMO_CYC   = 64
) (
  input logic                 clk,
  input logic                 rst,
  vend_dispense_ctrl_if.slave bus
);

  localparam int unsigned MotorMax = MOTOR_CYC + TMO_CYC;
  localparam int unsigned CntMaxA  = (MotorMax > PULSE_CYC) ? MotorMax : PULSE_CYC;
  localparam int unsigned CntMax   = (CntMaxA > GAP_CYC) ? CntMaxA : GAP_CYC;
  localparam int unsigned CntW     = $clog2(CntMax + 1);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StVend     = 3'd1;
  localparam logic [2:0] StChgPulse = 3'd2;
  localparam logic [2:0] StChgGap   = 3'd3;
  localparam logic [2:0] StDone     = 3'd4;
`ifdef VEND_TIMEOUT_EN
  localparam logic [2:0] StFault    = 3'd5;
`endif

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      chg_q, chg_d;
  logic            pend_v_q, pend_v_d;
  logic            pend_buy_q, pend_buy_d;
  logic [1:0]      pend_chg_q, pend_chg_d;
  logic            ovr_q, ovr_d;

  logic [1:0] ev_chg;
  logic       ev;
  logic       start;
  logic       st_buy;
  logic [1:0] st_chg;
  logic       vend_end;

  // Reserved code 11 behaves exactly like no change request.
  assign ev_chg = (bus.cash_return == 2'b11) ? 2'b00 : bus.cash_return;
  assign ev     = bus.purchase | (|ev_chg);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    chg_d      = chg_q;
    pend_v_d   = pend_v_q;
    pend_buy_d = pend_buy_q;
    pend_chg_d = pend_chg_q;
    ovr_d      = ovr_q;
    start      = 1'b0;
    st_buy     = 1'b0;
    st_chg     = 2'b00;
    vend_end   = 1'b0;

    if (state_q != StIdle && ev) begin
      if (!pend_v_q) begin
        pend_v_d   = 1'b1;
        pend_buy_d = bus.purchase;
        pend_chg_d = ev_chg;
      end else begin
        ovr_d = 1'b1;
      end
    end

    case (state_q)
      StIdle: begin
        if (pend_v_q) begin
          // Pending work wins; a simultaneous new event takes over the slot.
          start      = 1'b1;
          st_buy     = pend_buy_q;
          st_chg     = pend_chg_q;
          pend_v_d   = ev;
          pend_buy_d = bus.purchase;
          pend_chg_d = ev_chg;
        end else if (ev) begin
          start  = 1'b1;
          st_buy = bus.purchase;
          st_chg = ev_chg;
        end
      end
      StVend: begin
`ifdef VEND_TIMEOUT_EN
        if (cnt_q >= CntW'(MOTOR_CYC - 1)) begin
          if (bus.item_sensor) begin
            vend_end = 1'b1;
          end else if (cnt_q == CntW'(MotorMax - 1)) begin
            state_d  = StFault;
            cnt_d    = '0;
            pend_v_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`else
        if (cnt_q == CntW'(MOTOR_CYC - 1)) begin
          vend_end = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end
      StChgPulse: begin
        if (cnt_q == CntW'(PULSE_CYC - 1)) begin
          state_d = StChgGap;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StChgGap: begin
        if (cnt_q == CntW'(GAP_CYC - 1)) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: state_d = StIdle;
`ifdef VEND_TIMEOUT_EN
      StFault: begin
        pend_v_d = 1'b0;
        if (bus.fault_clr) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase

    if (vend_end) begin
      cnt_d   = '0;
      state_d = (chg_q != 2'b00) ? StChgPulse : StDone;
    end

    if (start) begin
      cnt_d   = '0;
      chg_d   = st_chg;
      state_d = st_buy ? StVend : StChgPulse;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      chg_q      <= 2'b00;
      pend_v_q   <= 1'b0;
      pend_buy_q <= 1'b0;
      pend_chg_q <= 2'b00;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      chg_q      <= chg_d;
      pend_v_q   <= pend_v_d;
      pend_buy_q <= pend_buy_d;
      pend_chg_q <= pend_chg_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus.motor_on   = (state_q == StVend);
  assign bus.coin5_out  = (state_q == StChgPulse) && (chg_q == 2'b01);
  assign bus.coin10_out = (state_q == StChgPulse) && (chg_q == 2'b10);
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = (state_q == StDone);
  assign bus.overrun    = ovr_q;
`ifdef VEND_TIMEOUT_EN
  assign bus.fault      = (state_q == StFault);
`else
  assign bus.fault      = 1'b0;
  logic unused_inputs;
  assign unused_inputs  = bus.item_sensor ^ bus.fault_clr;
`endif

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed bench for vend_dispense_ctrl: per-transaction cycle traces checked against hand-derived
// cycle numbers (event driven in cycle 0, outputs observed from cycle 1).
module tb_vend_dispense_ctrl;
  logic clk;
  logic rst;
  vend_dispense_ctrl_if bus_if ();

  vend_dispense_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  int m_cnt, m_first, m_last;
  int c5_cnt, c5_first, c5_last;
  int c10_cnt, c10_first, c10_last;
  int d_cnt, d_first, d_last;
  int idle_first, f_first, overlap;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Observe cycles 1..n; optional events at cycles c2/c3 and a reset pulse at cycle rc.
  task automatic obs(input int n, input int c2, input logic b2, input logic [1:0] k2,
                     input int c3, input logic b3, input logic [1:0] k3, input int rc);
    m_cnt = 0; m_first = 0; m_last = 0;
    c5_cnt = 0; c5_first = 0; c5_last = 0;
    c10_cnt = 0; c10_first = 0; c10_last = 0;
    d_cnt = 0; d_first = 0; d_last = 0;
    idle_first = 0; f_first = 0; overlap = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      bus_if.purchase    = 1'b0;
      bus_if.cash_return = 2'b00;
      rst                = 1'b0;
      if (i == c2) begin bus_if.purchase = b2; bus_if.cash_return = k2; end
      if (i == c3) begin bus_if.purchase = b3; bus_if.cash_return = k3; end
      if (i == rc) rst = 1'b1;
      if (bus_if.motor_on) begin m_cnt++; if (m_first == 0) m_first = i; m_last = i; end
      if (bus_if.coin5_out) begin c5_cnt++; if (c5_first == 0) c5_first = i; c5_last = i; end
      if (bus_if.coin10_out) begin c10_cnt++; if (c10_first == 0) c10_first = i; c10_last = i; end
      if (bus_if.done) begin d_cnt++; if (d_first == 0) d_first = i; d_last = i; end
      if (!bus_if.busy && idle_first == 0) idle_first = i;
      if (bus_if.fault && f_first == 0) f_first = i;
      if (int'(bus_if.motor_on) + int'(bus_if.coin5_out) + int'(bus_if.coin10_out) > 1) overlap++;
    end
  endtask

  task automatic kick(input logic b, input logic [1:0] k);
    @(negedge clk);
    bus_if.purchase    = b;
    bus_if.cash_return = k;
  endtask

  initial begin
    rst                = 1'b1;
    bus_if.purchase    = 1'b0;
    bus_if.cash_return = 2'b00;
    bus_if.item_sensor = 1'b1;
    bus_if.fault_clr   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_motor", int'(bus_if.motor_on), 0);
    check_eq("rst_busy", int'(bus_if.busy), 0);
    check_eq("rst_done", int'(bus_if.done), 0);
    check_eq("rst_ovr", int'(bus_if.overrun), 0);
    check_eq("rst_fault", int'(bus_if.fault), 0);

    // Plain vend: motor 1..16, done 17, idle 18.
    kick(1'b1, 2'b00);
    obs(24, 0, 1'b0, 2'b00, 0, 1'b0, 2'b00, 0);
    check_eq("v_m_cnt", m_cnt, 16);
    check_eq("v_m_first", m_first, 1);
    check_eq("v_m_last", m_last, 16);
    check_eq("v_d_first", d_first, 17);
    check_eq("v_d_cnt", d_cnt, 1);
    check_eq("v_idle", idle_first, 18);
    check_eq("v_coins", c5_cnt + c10_cnt, 0);
    check_eq("v_fault", f_first, 0);

    // Vend plus 10-unit change: coin10 17..20, gap 21..24, done 25.
    kick(1'b1, 2'b10);
    obs(30, 0, 1'b0, 2'b00, 0, 1'b0, 2'b00, 0);
    check_eq("vc_m_cnt", m_cnt, 16);
    check_eq("vc_c10_first", c10_first, 17);
    check_eq("vc_c10_last", c10_last, 20);
    check_eq("vc_c10_cnt", c10_cnt, 4);
    check_eq("vc_c5_cnt", c5_cnt, 0);
    check_eq("vc_d_first", d_first, 25);
    check_eq("vc_d_cnt", d_cnt, 1);
    check_eq("vc_idle", idle_first, 26);

    // Change only, 5-unit: coin5 1..4, done 9.
    kick(1'b0, 2'b01);
    obs(14, 0, 1'b0, 2'b00, 0, 1'b0, 2'b00, 0);
    check_eq("c5_first", c5_first, 1);
    check_eq("c5_last", c5_last, 4);
    check_eq("c5_m_cnt", m_cnt, 0);
    check_eq("c5_d_first", d_first, 9);
    check_eq("c5_idle", idle_first, 10);

    // Reserved code alone is not an event.
    kick(1'b0, 2'b11);
    obs(12, 0, 1'b0, 2'b00, 0, 1'b0, 2'b00, 0);
    check_eq("r11_idle", idle_first, 1);
    check_eq("r11_d_cnt", d_cnt, 0);
    check_eq("r11_coins", c5_cnt + c10_cnt + m_cnt, 0);

    // Event in DONE goes pending; event in the following IDLE displaces into the slot.
    kick(1'b1, 2'b00);
    obs(42, 17, 1'b0, 2'b10, 18, 1'b0, 2'b01, 0);
    check_eq("pr_c10_first", c10_first, 19);
    check_eq("pr_c5_first", c5_first, 29);
    check_eq("pr_c5_last", c5_last, 32);
    check_eq("pr_d_cnt", d_cnt, 3);
    check_eq("pr_d_last", d_last, 37);
    check_eq("pr_ovr", int'(bus_if.overrun), 0);

    // Three events in one vend: second after done, third dropped.
    kick(1'b1, 2'b00);
    obs(34, 3, 1'b0, 2'b01, 5, 1'b1, 2'b00, 0);
    check_eq("ov_m_cnt", m_cnt, 16);
    check_eq("ov_c5_first", c5_first, 19);
    check_eq("ov_d_cnt", d_cnt, 2);
    check_eq("ov_d_last", d_last, 27);
    check_eq("ov_ovr", int'(bus_if.overrun), 1);
    repeat (5) @(negedge clk);
    check_eq("ov_sticky", int'(bus_if.overrun), 1);

    // Reset mid-vend with a pending change: motor stops, no done, pending lost.
    kick(1'b1, 2'b00);
    obs(30, 3, 1'b0, 2'b01, 0, 1'b0, 2'b00, 5);
    check_eq("rs_m_cnt", m_cnt, 5);
    check_eq("rs_m_last", m_last, 5);
    check_eq("rs_idle", idle_first, 6);
    check_eq("rs_d_cnt", d_cnt, 0);
    check_eq("rs_c5_cnt", c5_cnt, 0);
    check_eq("rs_ovr", int'(bus_if.overrun), 0);

`ifdef VEND_TIMEOUT_EN
    // Sensor never fires: 80 motor cycles, then FAULT; change skipped, no done.
    @(negedge clk);
    bus_if.item_sensor = 1'b0;
    kick(1'b1, 2'b10);
    obs(90, 0, 1'b0, 2'b00, 0, 1'b0, 2'b00, 0);
    check_eq("to_m_cnt", m_cnt, 80);
    check_eq("to_f_first", f_first, 81);
    check_eq("to_c10_cnt", c10_cnt, 0);
    check_eq("to_d_cnt", d_cnt, 0);
    check_eq("to_fault_hold", int'(bus_if.fault), 1);
    @(negedge clk);
    bus_if.fault_clr = 1'b1;
    @(negedge clk);
    bus_if.fault_clr = 1'b0;
    check_eq("to_clr_busy", int'(bus_if.busy), 0);
    check_eq("to_clr_fault", int'(bus_if.fault), 0);
    check_eq("to_clr_done", int'(bus_if.done), 0);
    bus_if.item_sensor = 1'b1;
`endif

    check_eq("excl_overlap", overlap, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
